exponent_accelerator_debug_ocimem_ctrl: RTL and testbench

//  Sysclk-domain consumer of the debug-slave command strobes (take_*_ocimem_*) and the jdo payload.

---
 rtl/exponent_accelerator_debug_ocimem_ctrl_pkg.sv | 20 ++
 rtl/exponent_accelerator_debug_ocimem_ram.sv | 34 +++
 rtl/exponent_accelerator_debug_ocimem_ctrl.sv | 155 +++++++++++++++
 tb/tb_exponent_accelerator_debug_ocimem_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/exponent_accelerator_debug_ocimem_ctrl_pkg.sv
// Shared definitions for the OCI debug-memory controller.
// Contents: FSM state encoding, default RAM address width and the bit positions
// of the address and write-data fields inside the 38-bit jdo payload.
package exponent_accelerator_debug_ocimem_ctrl_pkg;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_JDO_ADDR_LSB = 26;
  localparam int DEF_JDO_DATA_LSB = 3;
  localparam int JDO_W            = 38;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_JRD      = 3'd1,
    ST_JRD_CAP  = 3'd2,
    ST_JWR      = 3'd3,
    ST_CRD      = 3'd4,
    ST_CRD_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/exponent_accelerator_debug_ocimem_ram.sv
// Single-port synchronous debug RAM, 32-bit words with four byte lanes.
// The read data is registered: q shows mem[addr] one clock after addr is
// presented. A read of the address being written returns the old word.
// Contents are deliberately not reset.
// Ports:
//   clk    in   system clock
//   addr   in   word address
//   we     in   write enable
//   be     in   byte-lane enables for the write
//   wdata  in   write data
//   q      out  registered read data
module exponent_accelerator_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/exponent_accelerator_debug_ocimem_ctrl.sv
// OCI debug-memory controller (system-clock side).
// Consumes the debug-slave command strobes and jdo payload, owns the debug
// RAM plus the monitor address/data registers, and shares the RAM with a
// CPU-side Avalon-MM slave. JTAG commands have priority over new CPU reads;
// a CPU read already in flight is allowed to finish first.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   jdo                       JTAG payload, valid while a take_* strobe is high
//   take_action_ocimem_a      load monitor address from jdo, queue JTAG read
//   take_no_action_ocimem_a   increment monitor address, queue JTAG read
//   take_action_ocimem_b      load MonDReg from jdo, queue JTAG write
//   MonDReg                   monitor data register (to scan chain)
//   jtag_busy                 JTAG command pending or in progress
//   av_*                      Avalon-MM slave port (word addressed)
//   dbg_state                 current FSM state (state_t encoding)
//
// Avalon handshake: a transfer is requested by holding av_read or av_write
// with stable address/data; it completes on the first rising edge at which
// av_waitrequest is low, and for reads av_readdata is valid in that cycle.
// av_waitrequest is high at all other times, including while in reset.
module exponent_accelerator_debug_ocimem_ctrl
  import exponent_accelerator_debug_ocimem_ctrl_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int JDO_ADDR_LSB = DEF_JDO_ADDR_LSB,
  parameter int JDO_DATA_LSB = DEF_JDO_DATA_LSB
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [2:0]        dbg_state
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] mon_a;
  logic              jrd_pend, jwr_pend;
  logic              any_take;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_data;
  logic              unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_data   = jdo[JDO_DATA_LSB +: 32];
  // Only two fields of jdo are meaningful here; fold the rest away.
  assign unused_jdo = ^jdo;

  assign any_take = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  assign jtag_busy = jrd_pend | jwr_pend |
                     (state == ST_JRD) | (state == ST_JRD_CAP) | (state == ST_JWR);
  assign dbg_state = state;

  exponent_accelerator_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  always_comb begin
    state_next     = state;
    ram_addr       = av_address;
    ram_we         = 1'b0;
    ram_be         = av_byteenable;
    ram_wdata      = av_writedata;
    av_waitrequest = 1'b1;
    av_readdata    = '0;
    case (state)
      ST_IDLE: begin
        if (jwr_pend)      state_next = ST_JWR;
        else if (jrd_pend) state_next = ST_JRD;
        // A strobe arriving this cycle becomes pending at this edge, so the
        // CPU read must not start yet or it would jump ahead of JTAG.
        else if (av_read && !any_take) state_next = ST_CRD;
        // Zero-wait CPU write; reset_n gating keeps the port stalled (and the
        // RAM untouched) while reset is held.
        if (av_write && !jwr_pend && !jrd_pend && reset_n) begin
          av_waitrequest = 1'b0;
          ram_we         = 1'b1;
        end
      end
      ST_JRD: begin
        ram_addr   = mon_a;
        state_next = ST_JRD_CAP;
      end
      ST_JRD_CAP: state_next = ST_IDLE;
      ST_JWR: begin
        ram_addr   = mon_a;
        ram_we     = 1'b1;
        ram_be     = 4'hF;
        ram_wdata  = MonDReg;
        state_next = ST_IDLE;
      end
      ST_CRD: state_next = ST_CRD_DONE;
      ST_CRD_DONE: begin
        av_readdata    = ram_q;
        av_waitrequest = 1'b0;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      mon_a    <= '0;
      MonDReg  <= '0;
      jrd_pend <= 1'b0;
      jwr_pend <= 1'b0;
    end else begin
      state <= state_next;
      // FSM side effects first; a strobe in the same cycle overrides them.
      if (state == ST_JRD)     jrd_pend <= 1'b0;
      if (state == ST_JRD_CAP) MonDReg  <= ram_q;
      if (state == ST_JWR) begin
        mon_a    <= mon_a + 1'b1;
        jwr_pend <= 1'b0;
      end
      if (take_action_ocimem_b) begin
        MonDReg  <= jdo_data;
        jwr_pend <= 1'b1;
        jrd_pend <= 1'b0;
      end else if (take_action_ocimem_a) begin
        mon_a    <= jdo_addr;
        jrd_pend <= 1'b1;
      end else if (take_no_action_ocimem_a) begin
        mon_a    <= mon_a + 1'b1;
        jrd_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exponent_accelerator_debug_ocimem_ctrl.sv
// Directed testbench for the OCI debug-memory controller.
module tb_exponent_accelerator_debug_ocimem_ctrl;
  import exponent_accelerator_debug_ocimem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_a, take_no, take_b;
  logic [31:0] MonDReg;
  logic        jtag_busy;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;
  int          n;

  exponent_accelerator_debug_ocimem_ctrl dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_no),
    .take_action_ocimem_b    (take_b),
    .MonDReg                 (MonDReg),
    .jtag_busy               (jtag_busy),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .dbg_state               (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int waits);
    av_address = a; av_writedata = d; av_byteenable = be; av_write = 1'b1;
    waits = 0;
    #1;
    while (av_waitrequest && waits < 50) begin tick(); waits++; end
    tick();
    av_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits);
    av_address = a; av_read = 1'b1;
    waits = 0;
    #1;
    while (av_waitrequest && waits < 50) begin tick(); waits++; end
    d = av_readdata;
    tick();
    av_read = 1'b0;
  endtask

  task automatic jtag_a(input logic [7:0] a);
    jdo = '0;
    jdo[DEF_JDO_ADDR_LSB +: 8] = a;
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
  endtask

  task automatic jtag_no();
    take_no = 1'b1;
    tick();
    take_no = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = '0;
    jdo[DEF_JDO_DATA_LSB +: 32] = d;
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
  endtask

  task automatic tick3();
    tick(); tick(); tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; jdo = '0; take_a = 0; take_no = 0; take_b = 0;
    av_address = '0; av_read = 0; av_write = 0; av_writedata = '0; av_byteenable = '0;
    tick(); tick();
    check("rst_mond", MonDReg, 32'h0);
    check("rst_busy", {31'b0, jtag_busy}, 32'h0);
    check("rst_waitreq", {31'b0, av_waitrequest}, 32'h1);
    check("rst_readdata", av_readdata, 32'h0);
    check("rst_state", {29'b0, dbg_state}, 32'h0);
    reset_n = 1'b1;
    tick();

    // 1: CPU write then JTAG read of the same word, 3-edge latency
    cpu_write(8'h10, 32'hDEADBEEF, 4'hF, n);
    check("t1_wr_waits", n, 0);
    jtag_a(8'h10);
    check("t1_busy_e0", {31'b0, jtag_busy}, 32'h1);
    tick();
    check("t1_busy_e1", {31'b0, jtag_busy}, 32'h1);
    tick();
    check("t1_busy_e2", {31'b0, jtag_busy}, 32'h1);
    check("t1_mond_early", MonDReg, 32'h0);
    tick();
    check("t1_busy_e3", {31'b0, jtag_busy}, 32'h0);
    check("t1_mond", MonDReg, 32'hDEADBEEF);

    // 2: JTAG write at 0xFF, monitor address wraps to 0
    jtag_a(8'hFF);
    tick3();
    jtag_b(32'h12345678);
    check("t2_mond_load", MonDReg, 32'h12345678);
    check("t2_busy_e0", {31'b0, jtag_busy}, 32'h1);
    tick();
    check("t2_state_jwr", {29'b0, dbg_state}, 32'd3);
    tick();
    check("t2_busy_e2", {31'b0, jtag_busy}, 32'h0);
    cpu_read(8'hFF, rd, n);
    check("t2_rd_ff", rd, 32'h12345678);
    check("t2_rd_waits", n, 2);
    cpu_write(8'h00, 32'h0000AAAA, 4'hF, n);
    cpu_write(8'h01, 32'h0000BBBB, 4'hF, n);
    jtag_no();
    tick3();
    check("t2_wrap", MonDReg, 32'h0000BBBB);

    // 3: load 0x05 then three increments
    for (int i = 5; i <= 8; i++) cpu_write(8'(i), 32'h50500000 + 32'(i), 4'hF, n);
    for (int i = 6; i <= 8; i++) exp_q.push_back(32'h50500000 + 32'(i));
    jtag_a(8'h05);
    tick3();
    check("t3_rd5", MonDReg, 32'h50500005);
    for (int i = 0; i < 3; i++) begin
      jtag_no();
      tick3();
      check("t3_incr", MonDReg, exp_q.pop_front());
    end

    // 4: CPU read and JTAG read requested in the same cycle; JTAG first
    cpu_write(8'h20, 32'hCAFEF00D, 4'hF, n);
    av_address = 8'h20; av_read = 1'b1;
    jdo = '0; jdo[DEF_JDO_ADDR_LSB +: 8] = 8'h10; take_a = 1'b1;
    tick();
    take_a = 1'b0;
    n = 1;
    while (av_waitrequest && n < 50) begin tick(); n++; end
    check("t4_stall_cycles", n, 6);
    check("t4_mond_first", MonDReg, 32'hDEADBEEF);
    check("t4_busy_done", {31'b0, jtag_busy}, 32'h0);
    check("t4_readdata", av_readdata, 32'hCAFEF00D);
    tick();
    av_read = 1'b0;

    // 5: partial byte-enable write
    cpu_write(8'h30, 32'h11111111, 4'hF, n);
    cpu_write(8'h30, 32'hAABBCCDD, 4'h3, n);
    cpu_read(8'h30, rd, n);
    check("t5_be", rd, 32'h1111CCDD);

    // 6: reset during a JTAG read, with a CPU write held
    jtag_a(8'h30);
    tick();
    check("t6_state_jrd", {29'b0, dbg_state}, 32'd1);
    av_address = 8'h10; av_writedata = 32'h0; av_byteenable = 4'hF; av_write = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t6_mond", MonDReg, 32'h0);
    check("t6_busy", {31'b0, jtag_busy}, 32'h0);
    check("t6_waitreq", {31'b0, av_waitrequest}, 32'h1);
    check("t6_state", {29'b0, dbg_state}, 32'h0);
    tick(); tick();
    check("t6_waitreq_held", {31'b0, av_waitrequest}, 32'h1);
    reset_n = 1'b1;
    av_write = 1'b0;
    tick();
    check("t6_busy_after", {31'b0, jtag_busy}, 32'h0);
    cpu_read(8'h10, rd, n);
    check("t6_ram10", rd, 32'hDEADBEEF);
    cpu_read(8'h30, rd, n);
    check("t6_ram30", rd, 32'h1111CCDD);
    cpu_read(8'hFF, rd, n);
    check("t6_ramff", rd, 32'h12345678);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
